// File: rtl/hp35_word_sequencer.sv
// HP-35 style 56-bit word timing: bit-time counter, serial ROM address
// shifter, instruction capture window and ROM bank selection.
module hp35_word_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       addr_load,
  input  logic [7:0] addr_in,
  input  logic       rom_sel_load,
  input  logic [1:0] rom_sel_in,
  input  logic       is_in,
  output logic [5:0] bit_time,
  output logic       sync,
  output logic       ia_out,
  output logic [2:0] rom_en,
  output logic [9:0] instr,
  output logic       instr_valid,
  output logic       word_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  bt_q, bt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  pa_q, pa_d;
  logic        pend_q, pend_d;
  logic [1:0]  rsel_q, rsel_d;
  logic        rpend_q, rpend_d;
  logic [2:0]  rom_q, rom_d;
  logic [9:0]  cap_q, cap_d;
  logic [9:0]  instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        running;
  logic        word_end;
  logic        sync_win;
  logic        ia_win;
  logic [3:0]  cidx;

  assign running  = (state_q == RUN);
  assign word_end = running && (bt_q == 6'd55);
  assign sync_win = running && (bt_q >= 6'd45) && (bt_q <= 6'd54);
  assign ia_win   = running && (bt_q >= 6'd19) && (bt_q <= 6'd26);
  assign cidx     = 4'(bt_q - 6'd45);

  always_comb begin
    state_d = state_q;
    bt_d    = bt_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    pa_d    = pa_q;
    pend_d  = pend_q;
    rsel_d  = rsel_q;
    rpend_d = rpend_q;
    rom_d   = rom_q;
    cap_d   = cap_q;
    instr_d = instr_q;
    valid_d = 1'b0;

    // Requests latch in any state; a same-cycle load is thus seen below.
    if (addr_load) begin
      pa_d   = addr_in;
      pend_d = 1'b1;
    end
    if (rom_sel_load && (rom_sel_in != 2'd3)) begin
      rsel_d  = rom_sel_in;
      rpend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        bt_d = 6'd0;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (word_end) begin
          bt_d    = 6'd0;
          valid_d = 1'b1;
          instr_d = cap_q;
          if (!run) state_d = IDLE;
          addr_d  = pend_d ? pa_d : addr_q + 8'd1;
          sh_d    = addr_d;
          pend_d  = 1'b0;
          if (rpend_d) rom_d = 3'b001 << rsel_d;
          rpend_d = 1'b0;
        end else begin
          bt_d = bt_q + 6'd1;
          if (sync_win) cap_d[cidx] = is_in;
          if (ia_win) sh_d = {1'b0, sh_q[7:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bt_q    <= 6'd0;
      addr_q  <= 8'd0;
      sh_q    <= 8'd0;
      pa_q    <= 8'd0;
      pend_q  <= 1'b0;
      rsel_q  <= 2'd0;
      rpend_q <= 1'b0;
      rom_q   <= 3'b001;
      cap_q   <= 10'd0;
      instr_q <= 10'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bt_q    <= bt_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      pa_q    <= pa_d;
      pend_q  <= pend_d;
      rsel_q  <= rsel_d;
      rpend_q <= rpend_d;
      rom_q   <= rom_d;
      cap_q   <= cap_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bit_time    = bt_q;
  assign sync        = sync_win;
  assign ia_out      = ia_win & sh_q[0];
  assign rom_en      = rom_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign word_done   = valid_q;

endmodule

// File: tb/tb_hp35_word_sequencer.sv
// Bench for hp35_word_sequencer: directed word scenarios plus random
// traffic, all checked against a word-level reference model.
module tb_hp35_word_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       addr_load;
  logic [7:0] addr_in;
  logic       rom_sel_load;
  logic [1:0] rom_sel_in;
  logic       is_in;
  logic [5:0] bit_time;
  logic       sync;
  logic       ia_out;
  logic [2:0] rom_en;
  logic [9:0] instr;
  logic       instr_valid;
  logic       word_done;

  hp35_word_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .addr_load    (addr_load),
    .addr_in      (addr_in),
    .rom_sel_load (rom_sel_load),
    .rom_sel_in   (rom_sel_in),
    .is_in        (is_in),
    .bit_time     (bit_time),
    .sync         (sync),
    .ia_out       (ia_out),
    .rom_en       (rom_en),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .word_done    (word_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: word-level view of the sequencer
  bit m_run;
  int m_bt;
  int m_addr;
  bit m_pend;
  int m_pa;
  int m_rom;
  bit m_rpend;
  int m_rsel;
  bit m_cap [10];
  int m_instr;
  bit m_valid;
  bit cur_run;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_bt = 0; m_addr = 0; m_pend = 0; m_pa = 0;
    m_rom = 0; m_rpend = 0; m_rsel = 0; m_instr = 0; m_valid = 0;
    foreach (m_cap[i]) m_cap[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit al, input int ai,
                            input bit rl, input int ri, input bit isv);
    m_valid = 0;
    if (m_run && m_bt == 55) begin
      if (al) m_addr = ai;
      else if (m_pend) m_addr = m_pa;
      else m_addr = (m_addr + 1) % 256;
      m_pend = 0;
      if (rl && ri != 3) m_rom = ri;
      else if (m_rpend) m_rom = m_rsel;
      m_rpend = 0;
      m_instr = 0;
      for (int i = 0; i < 10; i++) m_instr += int'(m_cap[i]) << i;
      m_valid = 1;
      m_bt = 0;
      m_run = r;
    end else begin
      if (al) begin m_pa = ai; m_pend = 1; end
      if (rl && ri != 3) begin m_rsel = ri; m_rpend = 1; end
      if (m_run) begin
        if (m_bt >= 45 && m_bt <= 54) m_cap[m_bt - 45] = isv;
        m_bt++;
      end else begin
        m_bt = 0;
        if (r) m_run = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit s, a;
    s = m_run && m_bt >= 45 && m_bt <= 54;
    a = m_run && m_bt >= 19 && m_bt <= 26 && (((m_addr >> (m_bt - 19)) & 1) == 1);
    check("bit_time", 32'(bit_time), 32'(m_bt));
    check("sync", 32'(sync), 32'(s));
    check("ia_out", 32'(ia_out), 32'(a));
    check("rom_en", 32'(rom_en), 32'(1 << m_rom));
    check("instr", 32'(instr), 32'(m_instr));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("word_done", 32'(word_done), 32'(m_valid));
  endtask

  // called at a falling edge: check, drive, advance one clock
  task automatic step(input bit r, input bit al, input logic [7:0] ai,
                      input bit rl, input logic [1:0] ri, input bit isv);
    check_outputs();
    run = r; addr_load = al; addr_in = ai;
    rom_sel_load = rl; rom_sel_in = ri; is_in = isv;
    model_step(r, al, int'(ai), rl, int'(ri), isv);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(cur_run, 0, 8'h00, 0, 2'd0, 1'($urandom));
  endtask

  task automatic run_to(input int target);
    int budget = 200;
    while (!(m_run && m_bt == target) && budget > 0) begin
      idle_step();
      budget--;
    end
    if (budget == 0) check("run_to_timeout", 32'(m_bt), 32'(target));
  endtask

  task automatic check_word(input string tag, input logic [7:0] w);
    run_to(19);
    for (int i = 0; i < 8; i++) begin
      check(tag, 32'(ia_out), 32'(w[i]));
      idle_step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bt"}, 32'(bit_time), 0);
    check({tag, "_sync"}, 32'(sync), 0);
    check({tag, "_ia"}, 32'(ia_out), 0);
    check({tag, "_rom"}, 32'(rom_en), 32'h1);
    check({tag, "_instr"}, 32'(instr), 0);
    check({tag, "_valid"}, 32'(instr_valid), 0);
    check({tag, "_done"}, 32'(word_done), 0);
  endtask

  initial begin
    int nsync, ndone;
    logic [9:0] pat;
    reset = 1; run = 0; addr_load = 0; addr_in = 0;
    rom_sel_load = 0; rom_sel_in = 0; is_in = 0;
    cur_run = 0;
    model_reset();
    #3;
    check_reset_vals("por");
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // three free-running words
    cur_run = 1;
    idle_step();
    nsync = 0; ndone = 0;
    for (int i = 0; i < 168; i++) begin
      if (sync) nsync++;
      if (word_done) ndone++;
      idle_step();
    end
    check("sync_count", 32'(nsync), 30);
    check("done_count", 32'(ndone), 2);

    // mid-word address load, then increment
    run_to(30);
    step(1, 1, 8'hA5, 0, 2'd0, 0);
    check_word("ia_a5", 8'hA5);
    check_word("ia_a6", 8'hA6);

    run_to(30);
    step(1, 1, 8'hFF, 0, 2'd0, 0);
    check_word("ia_ff", 8'hFF);
    check_word("ia_00", 8'h00);

    run_to(30);
    step(1, 1, 8'h10, 0, 2'd0, 0);
    run_to(40);
    step(1, 1, 8'h20, 0, 2'd0, 0);
    check_word("ia_20", 8'h20);

    // instruction capture
    pat = 10'b1100110101;
    run_to(45);
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00, 0, 2'd0, pat[i]);
    run_to(0);
    check("instr_335", 32'(instr), 32'h335);
    check("instr_vld", 32'(instr_valid), 1);
    idle_step();
    check("instr_vld_once", 32'(instr_valid), 0);

    // ROM select
    run_to(10);
    step(1, 0, 8'h00, 1, 2'd2, 0);
    run_to(55);
    check("rom_hold", 32'(rom_en), 32'h1);
    idle_step();
    check("rom_sw", 32'(rom_en), 32'h4);
    run_to(10);
    step(1, 0, 8'h00, 1, 2'd3, 0);
    run_to(0);
    check("rom_inv", 32'(rom_en), 32'h4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, al, rl;
      r  = ($urandom % 64) != 0;
      al = ($urandom % 20) == 0;
      rl = ($urandom % 30) == 0;
      step(r, al, 8'($urandom), rl, 2'($urandom), 1'($urandom));
    end

    // stop mid-word, then reset mid-word
    cur_run = 1;
    run_to(20);
    cur_run = 0;
    begin
      int budget = 100;
      while (m_run && budget > 0) begin idle_step(); budget--; end
    end
    idle_step();
    check("idle_bt", 32'(bit_time), 0);
    check("idle_sync", 32'(sync), 0);
    cur_run = 1;
    run_to(50);
    reset = 1;
    #1;
    check_reset_vals("mid");
    run = 0;
    model_reset();
    cur_run = 0;
    #2 reset = 0;
    @(negedge clk);
    idle_step();
    check("post_instr", 32'(instr), 0);
    cur_run = 1;
    for (int i = 0; i < 120; i++) idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
